// File: rtl/debug_slave_sysclk_cmdq.sv
// System-clock side of the JTAG debug slave.
// Brings the tck-domain update strobes into clk, queues every completed DR scan
// together with its IR code, and emits one-cycle per-command pulses as the
// consumer pops entries.
module debug_slave_sysclk_cmdq #(
  parameter int IR_W        = 2,
  parameter int DR_W        = 38,
  parameter int ACTION_BIT  = 34,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              vs_uir,
  input  logic                              vs_udr,
  input  logic [IR_W-1:0]                   ir_in,
  input  logic [DR_W-1:0]                   sr,
  input  logic                              cmd_ready,
  input  logic                              clear_overflow,
  output logic                              cmd_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   cmd_count,
  output logic [DR_W-1:0]                   jdo,
  output logic [IR_W-1:0]                   jdo_ir,
  output logic [2**IR_W-1:0]                take_action,
  output logic [2**IR_W-1:0]                take_no_action,
  output logic                              overflow
);
  localparam int NUM_CMD = 2**IR_W;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = $clog2(FIFO_DEPTH+1);
  localparam int EW      = IR_W + DR_W;

  logic [SYNC_STAGES-1:0] uir_sync, udr_sync, fill;
  logic uir_s, udr_s, fill_done;
  logic uir_armed, udr_armed, uir_prev, udr_prev;
  logic uir_ev, udr_ev;
  logic [IR_W-1:0] ir_latch;

  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            full, pop, push, drop;
  logic [EW-1:0]   head;
  logic [IR_W-1:0] head_ir;
  logic [DR_W-1:0] head_dr;
  logic [NUM_CMD-1:0] onehot;

  // Strobe synchronisers; 'fill' marks when the chain output holds a real
  // post-reset sample rather than the reset value.
  always_ff @(posedge clk) begin
    if (reset) begin
      uir_sync <= '0;
      udr_sync <= '0;
      fill     <= '0;
    end else begin
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      fill     <= {fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign uir_s     = uir_sync[SYNC_STAGES-1];
  assign udr_s     = udr_sync[SYNC_STAGES-1];
  assign fill_done = fill[SYNC_STAGES-1];

  // Rising-edge detectors; they only arm once a genuine low has been seen, so a
  // strobe already high when reset drops is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      uir_armed <= 1'b0;
      udr_armed <= 1'b0;
      uir_prev  <= 1'b0;
      udr_prev  <= 1'b0;
    end else begin
      uir_armed <= uir_armed | (fill_done & ~uir_s);
      udr_armed <= udr_armed | (fill_done & ~udr_s);
      uir_prev  <= uir_s;
      udr_prev  <= udr_s;
    end
  end

  assign uir_ev = uir_armed & uir_s & ~uir_prev;
  assign udr_ev = udr_armed & udr_s & ~udr_prev;

  // IR latch; a push in the same cycle sees the old value.
  always_ff @(posedge clk) begin
    if (reset)       ir_latch <= '0;
    else if (uir_ev) ir_latch <= ir_in;
  end

  assign cmd_valid = (count != '0);
  assign cmd_count = count;
  assign full      = (count == CW'(FIFO_DEPTH));
  assign pop       = cmd_valid & cmd_ready;
  // When full, a push is only accepted if the head leaves in the same cycle.
  assign push      = udr_ev & (~full | pop);
  assign drop      = udr_ev & full & ~pop;

  // Queue storage; no reset needed, occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {ir_latch, sr};
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head    = mem[rd_ptr];
  assign head_ir = head[EW-1:DR_W];
  assign head_dr = head[DR_W-1:0];

  // Decode the head IR to its command line.
  always_comb begin
    onehot = '0;
    onehot[head_ir] = 1'b1;
  end

  // Pop side: load jdo/jdo_ir and fire exactly one pulse for one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      jdo            <= '0;
      jdo_ir         <= '0;
      take_action    <= '0;
      take_no_action <= '0;
    end else begin
      take_action    <= '0;
      take_no_action <= '0;
      if (pop) begin
        jdo    <= head_dr;
        jdo_ir <= head_ir;
        if (head_dr[ACTION_BIT]) take_action    <= onehot;
        else                     take_no_action <= onehot;
      end
    end
  end

  // Sticky overflow; a drop in the same cycle beats a clear.
  always_ff @(posedge clk) begin
    if (reset)               overflow <= 1'b0;
    else if (drop)           overflow <= 1'b1;
    else if (clear_overflow) overflow <= 1'b0;
  end
endmodule
